mem_wb_pipe_reg: RTL and testbench
==================================

# mem_wb_pipe_reg

Parametrised MEM/WB pipeline register for the pipelined MIPS core. It sits between data-memory access and register-file writeback and captures RAM read data, ALU/immediate result, PC, destination register and WB control. Over the plain MEM/WB register it adds synchronous reset, stall (hold), flush (bubble insertion), a valid bit, r0 write suppression, a registered-state writeback mux and MEM/WB-stage forwarding match flags.

## Interface
- DATA_W, 32, width of RAM and immediate data paths
- ADDR_W, 32, PC width
- REG_ADDR_W, 5, register-file index width
- PC_INC, 4, link offset added to PC for MemtoReg = 2
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  reset, synchronous, active-high
- In_Stall  input  1  hold all state this cycle
- In_Flush  input  1  load a bubble this cycle
- In_Valid  input  1  upstream stage holds a real instruction
- In_RAM_Data  input  DATA_W  data-memory read data
- In_Immediate_Data  input  DATA_W  ALU/immediate result
- In_PC  input  ADDR_W  instruction PC
- In_Rd  input  REG_ADDR_W  destination register
- In_RegWrite  input  1  register write enable
- In_MemtoReg  input  2  writeback source select
- In_Rs, In_Rt  input  REG_ADDR_W  EX-stage source registers for forwarding compare
- Out_RAM_Data, Out_Immediate_Data  output  DATA_W  registered copies
- Out_PC  output  ADDR_W  registered PC
- Out_Rd  output  REG_ADDR_W  registered destination
- Out_RegWrite  output  1  qualified write enable
- Out_MemtoReg  output  2  registered select
- Out_Valid  output  1  stage holds a real instruction
- Out_WB_Data  output  DATA_W  selected writeback value
- Out_Fwd_Rs, Out_Fwd_Rt  output  1  forward from this stage to EX
- Out_Retired  output  32  retired-instruction count (macro only)

## Operation
- Per-edge priority: rst > In_Flush > In_Stall > load.
- rst: every registered output goes to 0, including Out_Valid and Out_Retired.
- Flush: Out_Valid, Out_RegWrite, Out_MemtoReg and Out_Rd go to 0. Data fields and Out_PC hold.
- Stall without flush: all registers hold their values.
- Load: all fields capture their inputs. Out_Valid <= In_Valid. Out_RegWrite <= In_RegWrite & In_Valid & (In_Rd != 0).
- Out_WB_Data is combinational from registered state only:
  - MemtoReg 00: Out_Immediate_Data
  - MemtoReg 01: Out_RAM_Data
  - MemtoReg 10: Out_PC + PC_INC, zero-extended or truncated to DATA_W; addition wraps
  - MemtoReg 11: 0
- Out_Fwd_Rs = Out_RegWrite & (Out_Rd == In_Rs). Out_Fwd_Rt uses In_Rt the same way.
- Out_RegWrite already implies Out_Valid and Out_Rd != 0, so r0 never forwards.

## Timing
- Latency is 1 cycle from input to registered output.
- Out_WB_Data has zero added latency after the register.
- Out_Fwd_* is combinational from In_Rs/In_Rt in the same cycle.
- No handshake: In_Stall is level-sensitive and applies per edge. A long stall holds indefinitely.
- Flush and stall asserted together: flush wins and the bubble is loaded.
- rst asserted mid-stall or mid-flush: reset wins and all outputs are 0 after that edge.
- First edge after rst deasserts loads normally.

## Configuration
- MEM_WB_RETIRE_CNT_EN defined:
  - Out_Retired increments by 1 on every load edge (no rst, no flush, no stall) where In_Valid = 1.
  - Wraps 0xFFFFFFFF -> 0. Flush and stall do not change it. Reset clears it.
- Undefined: Out_Retired is tied to 0 and no counter flops exist.

## Test plan
- Reset: rst=1 for 2 edges with non-zero inputs -> all outputs 0. Release, load Rd=5, RegWrite=1, Valid=1, Imm=0x1234 -> next cycle Out_RegWrite=1, Out_Rd=5, Out_WB_Data=0x1234.
- Stall/flush: load RAM_Data=0xDEADBEEF, MemtoReg=01, then In_Stall=1 for 3 cycles with new inputs -> outputs unchanged. Then In_Flush=1 together with In_Stall=1 -> Out_Valid=0, Out_RegWrite=0, Out_Rd=0, Out_RAM_Data still 0xDEADBEEF.
- r0 suppression: load Rd=0, RegWrite=1, Valid=1 -> Out_RegWrite=0. With In_Rs=0, Out_Fwd_Rs=0.
- Forwarding and link: load Rd=9, RegWrite=1. In_Rs=9, In_Rt=3 -> Out_Fwd_Rs=1, Out_Fwd_Rt=0. Load PC=0x00400010, MemtoReg=10 -> Out_WB_Data=0x00400014. MemtoReg=11 -> 0.
- Retire counter (macro on): 10 valid loads, 2 stalled cycles, 1 flush, 1 load with In_Valid=0 -> Out_Retired=10. Force counter to 0xFFFFFFFF, one valid load -> 0.
- Macro off: the same sequence -> Out_Retired stays 0.

Source files
------------

// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline register: stall, flush, valid, r0 write suppression, writeback mux, forwarding flags.
// Define MEM_WB_RETIRE_CNT_EN to build the retired-instruction counter on Out_Retired.
module mem_wb_pipe_reg #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned PC_INC     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  In_Stall,
  input  logic                  In_Flush,
  input  logic                  In_Valid,
  input  logic [DATA_W-1:0]     In_RAM_Data,
  input  logic [DATA_W-1:0]     In_Immediate_Data,
  input  logic [ADDR_W-1:0]     In_PC,
  input  logic [REG_ADDR_W-1:0] In_Rd,
  input  logic                  In_RegWrite,
  input  logic [1:0]            In_MemtoReg,
  input  logic [REG_ADDR_W-1:0] In_Rs,
  input  logic [REG_ADDR_W-1:0] In_Rt,
  output logic [DATA_W-1:0]     Out_RAM_Data,
  output logic [DATA_W-1:0]     Out_Immediate_Data,
  output logic [ADDR_W-1:0]     Out_PC,
  output logic [REG_ADDR_W-1:0] Out_Rd,
  output logic                  Out_RegWrite,
  output logic [1:0]            Out_MemtoReg,
  output logic                  Out_Valid,
  output logic [DATA_W-1:0]     Out_WB_Data,
  output logic                  Out_Fwd_Rs,
  output logic                  Out_Fwd_Rt,
  output logic [31:0]           Out_Retired
);

  localparam int unsigned CNT_W = 32;

  typedef struct packed {
    logic [DATA_W-1:0]     ram_data;
    logic [DATA_W-1:0]     imm_data;
    logic [ADDR_W-1:0]     pc;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic [1:0]            mem_to_reg;
    logic                  valid;
  } stage_t;

  stage_t              stage_q;
  stage_t              stage_d;
  logic                load_en;
  logic [ADDR_W-1:0]   link_addr;

  assign load_en = !In_Flush && !In_Stall;

  // Next-stage payload; a write to r0 or from a bubble is never architecturally visible.
  always_comb begin
    stage_d            = '0;
    stage_d.ram_data   = In_RAM_Data;
    stage_d.imm_data   = In_Immediate_Data;
    stage_d.pc         = In_PC;
    stage_d.rd         = In_Rd;
    stage_d.reg_write  = In_RegWrite && In_Valid && (In_Rd != '0);
    stage_d.mem_to_reg = In_MemtoReg;
    stage_d.valid      = In_Valid;
  end

  // Priority per edge: reset, flush (bubble keeps data/PC), stall (hold), load.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else if (In_Flush) begin
      stage_q.valid      <= 1'b0;
      stage_q.reg_write  <= 1'b0;
      stage_q.mem_to_reg <= 2'b00;
      stage_q.rd         <= '0;
    end else if (load_en) begin
      stage_q <= stage_d;
    end
  end

  assign Out_RAM_Data       = stage_q.ram_data;
  assign Out_Immediate_Data = stage_q.imm_data;
  assign Out_PC             = stage_q.pc;
  assign Out_Rd             = stage_q.rd;
  assign Out_RegWrite       = stage_q.reg_write;
  assign Out_MemtoReg       = stage_q.mem_to_reg;
  assign Out_Valid          = stage_q.valid;

  // Link address wraps in PC width, then is resized to the data width.
  assign link_addr = stage_q.pc + ADDR_W'(PC_INC);

  always_comb begin
    Out_WB_Data = '0;
    unique case (stage_q.mem_to_reg)
      2'b00:   Out_WB_Data = stage_q.imm_data;
      2'b01:   Out_WB_Data = stage_q.ram_data;
      2'b10:   Out_WB_Data = DATA_W'(link_addr);
      default: Out_WB_Data = '0;
    endcase
  end

  // reg_write already excludes bubbles and r0, so no extra qualification is needed.
  assign Out_Fwd_Rs = stage_q.reg_write && (stage_q.rd == In_Rs);
  assign Out_Fwd_Rt = stage_q.reg_write && (stage_q.rd == In_Rt);

`ifdef MEM_WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] retire_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_q <= '0;
    end else if (load_en && In_Valid) begin
      retire_cnt_q <= retire_cnt_q + CNT_W'(1);
    end
  end

  assign Out_Retired = retire_cnt_q;
`else
  assign Out_Retired = '0;
`endif

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Directed self-checking bench for mem_wb_pipe_reg; follows MEM_WB_RETIRE_CNT_EN like the design.
module tb_mem_wb_pipe_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        In_Stall, In_Flush, In_Valid;
  logic [31:0] In_RAM_Data, In_Immediate_Data, In_PC;
  logic [4:0]  In_Rd, In_Rs, In_Rt;
  logic        In_RegWrite;
  logic [1:0]  In_MemtoReg;
  logic [31:0] Out_RAM_Data, Out_Immediate_Data, Out_PC, Out_WB_Data, Out_Retired;
  logic [4:0]  Out_Rd;
  logic        Out_RegWrite, Out_Valid, Out_Fwd_Rs, Out_Fwd_Rt;
  logic [1:0]  Out_MemtoReg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wb_pipe_reg #(.DATA_W(32), .ADDR_W(32), .REG_ADDR_W(5), .PC_INC(4)) dut (
    .clk(clk), .rst(rst),
    .In_Stall(In_Stall), .In_Flush(In_Flush), .In_Valid(In_Valid),
    .In_RAM_Data(In_RAM_Data), .In_Immediate_Data(In_Immediate_Data),
    .In_PC(In_PC), .In_Rd(In_Rd), .In_RegWrite(In_RegWrite), .In_MemtoReg(In_MemtoReg),
    .In_Rs(In_Rs), .In_Rt(In_Rt),
    .Out_RAM_Data(Out_RAM_Data), .Out_Immediate_Data(Out_Immediate_Data),
    .Out_PC(Out_PC), .Out_Rd(Out_Rd), .Out_RegWrite(Out_RegWrite),
    .Out_MemtoReg(Out_MemtoReg), .Out_Valid(Out_Valid), .Out_WB_Data(Out_WB_Data),
    .Out_Fwd_Rs(Out_Fwd_Rs), .Out_Fwd_Rt(Out_Fwd_Rt), .Out_Retired(Out_Retired)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] ram, input logic [31:0] imm,
                        input logic [31:0] pc, input logic [4:0] rd, input logic rw,
                        input logic [1:0] mtr);
    In_Valid = v; In_RAM_Data = ram; In_Immediate_Data = imm;
    In_PC = pc; In_Rd = rd; In_RegWrite = rw; In_MemtoReg = mtr;
  endtask

  task automatic test_reset();
    rst = 1'b1; In_Stall = 1'b0; In_Flush = 1'b0;
    In_Rs = 5'd7; In_Rt = 5'd7;
    set_in(1'b1, 32'hAAAA5555, 32'h1111, 32'h400, 5'd7, 1'b1, 2'b01);
    step(); step();
    checks++;
    if ({Out_RAM_Data, Out_Immediate_Data, Out_PC} !== 96'd0) begin
      errors++; $display("FAIL reset_data: got %h/%h/%h want 0", Out_RAM_Data, Out_Immediate_Data, Out_PC);
    end
    checks++;
    if ({Out_Rd, Out_RegWrite, Out_MemtoReg, Out_Valid, Out_Fwd_Rs, Out_Fwd_Rt} !== 11'd0) begin
      errors++; $display("FAIL reset_ctrl: rd=%0d rw=%b mtr=%b v=%b fwd=%b%b want 0",
                         Out_Rd, Out_RegWrite, Out_MemtoReg, Out_Valid, Out_Fwd_Rs, Out_Fwd_Rt);
    end
    checks++;
    if (Out_WB_Data !== 32'd0 || Out_Retired !== 32'd0) begin
      errors++; $display("FAIL reset_wb_ret: wb=%h ret=%0d want 0", Out_WB_Data, Out_Retired);
    end
    rst = 1'b0;
    set_in(1'b1, 32'h0, 32'h1234, 32'h0, 5'd5, 1'b1, 2'b00);
    step();
    checks++;
    if (Out_RegWrite !== 1'b1 || Out_Rd !== 5'd5 || Out_WB_Data !== 32'h1234 || Out_Valid !== 1'b1) begin
      errors++; $display("FAIL first_load: rw=%b rd=%0d wb=%h v=%b want 1/5/00001234/1",
                         Out_RegWrite, Out_Rd, Out_WB_Data, Out_Valid);
    end
  endtask

  task automatic test_stall_flush();
    set_in(1'b1, 32'hDEADBEEF, 32'h55, 32'h100, 5'd7, 1'b1, 2'b01);
    step();
    checks++;
    if (Out_WB_Data !== 32'hDEADBEEF || Out_RegWrite !== 1'b1 || Out_Rd !== 5'd7) begin
      errors++; $display("FAIL ram_load: wb=%h rw=%b rd=%0d want deadbeef/1/7", Out_WB_Data, Out_RegWrite, Out_Rd);
    end
    In_Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'h1000 + i, 32'h2000 + i, 32'h3000 + i, 5'd10 + 5'(i), 1'b1, 2'b00);
      step();
      checks++;
      if (Out_RAM_Data !== 32'hDEADBEEF || Out_Immediate_Data !== 32'h55 || Out_PC !== 32'h100 ||
          Out_Rd !== 5'd7 || Out_MemtoReg !== 2'b01 || Out_Valid !== 1'b1 || Out_RegWrite !== 1'b1) begin
        errors++; $display("FAIL stall_hold[%0d]: ram=%h imm=%h pc=%h rd=%0d mtr=%b v=%b rw=%b", i,
                           Out_RAM_Data, Out_Immediate_Data, Out_PC, Out_Rd, Out_MemtoReg, Out_Valid, Out_RegWrite);
      end
    end
    In_Flush = 1'b1;
    step();
    checks++;
    if (Out_Valid !== 1'b0 || Out_RegWrite !== 1'b0 || Out_Rd !== 5'd0 || Out_MemtoReg !== 2'b00) begin
      errors++; $display("FAIL flush_ctrl: v=%b rw=%b rd=%0d mtr=%b want 0", Out_Valid, Out_RegWrite, Out_Rd, Out_MemtoReg);
    end
    checks++;
    if (Out_RAM_Data !== 32'hDEADBEEF || Out_PC !== 32'h100 || Out_WB_Data !== 32'h55) begin
      errors++; $display("FAIL flush_data: ram=%h pc=%h wb=%h want deadbeef/100/55", Out_RAM_Data, Out_PC, Out_WB_Data);
    end
    In_Flush = 1'b0;
    set_in(1'b1, 32'h77, 32'h88, 32'h99, 5'd3, 1'b1, 2'b00);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (Out_Immediate_Data !== 32'd0 || Out_PC !== 32'd0 || Out_Valid !== 1'b0 || Out_Rd !== 5'd0) begin
      errors++; $display("FAIL reset_in_stall: imm=%h pc=%h v=%b rd=%0d want 0", Out_Immediate_Data, Out_PC, Out_Valid, Out_Rd);
    end
    In_Stall = 1'b0;
  endtask

  task automatic test_r0_suppress();
    In_Rs = 5'd0; In_Rt = 5'd0;
    set_in(1'b1, 32'h0, 32'hCAFE, 32'h0, 5'd0, 1'b1, 2'b00);
    step();
    checks++;
    if (Out_RegWrite !== 1'b0 || Out_Valid !== 1'b1 || Out_Fwd_Rs !== 1'b0 || Out_Fwd_Rt !== 1'b0) begin
      errors++; $display("FAIL r0_write: rw=%b v=%b fwd=%b%b want 0/1/00", Out_RegWrite, Out_Valid, Out_Fwd_Rs, Out_Fwd_Rt);
    end
    In_Rs = 5'd4;
    set_in(1'b0, 32'h0, 32'hCAFE, 32'h0, 5'd4, 1'b1, 2'b00);
    step();
    checks++;
    if (Out_RegWrite !== 1'b0 || Out_Valid !== 1'b0 || Out_Fwd_Rs !== 1'b0) begin
      errors++; $display("FAIL invalid_write: rw=%b v=%b fwd_rs=%b want 0/0/0", Out_RegWrite, Out_Valid, Out_Fwd_Rs);
    end
  endtask

  task automatic test_fwd_link();
    set_in(1'b1, 32'h0, 32'h9, 32'h0, 5'd9, 1'b1, 2'b00);
    step();
    In_Rs = 5'd9; In_Rt = 5'd3;
    #1;
    checks++;
    if (Out_Fwd_Rs !== 1'b1 || Out_Fwd_Rt !== 1'b0) begin
      errors++; $display("FAIL fwd_rs: got %b%b want 10", Out_Fwd_Rs, Out_Fwd_Rt);
    end
    In_Rs = 5'd3; In_Rt = 5'd9;
    #1;
    checks++;
    if (Out_Fwd_Rs !== 1'b0 || Out_Fwd_Rt !== 1'b1) begin
      errors++; $display("FAIL fwd_rt: got %b%b want 01", Out_Fwd_Rs, Out_Fwd_Rt);
    end
    set_in(1'b1, 32'h1, 32'h2, 32'h00400010, 5'd31, 1'b1, 2'b10);
    step();
    checks++;
    if (Out_WB_Data !== 32'h00400014) begin
      errors++; $display("FAIL link: got %h want 00400014", Out_WB_Data);
    end
    set_in(1'b1, 32'h1, 32'h2, 32'h00400010, 5'd31, 1'b1, 2'b11);
    step();
    checks++;
    if (Out_WB_Data !== 32'd0) begin
      errors++; $display("FAIL sel_11: got %h want 0", Out_WB_Data);
    end
    set_in(1'b1, 32'h1, 32'h2, 32'hFFFFFFFC, 5'd31, 1'b1, 2'b10);
    step();
    checks++;
    if (Out_WB_Data !== 32'd0) begin
      errors++; $display("FAIL link_wrap: got %h want 0", Out_WB_Data);
    end
  endtask

  task automatic test_retire();
    logic [31:0] exp_cnt;
    logic [31:0] exp_wrap;
`ifdef MEM_WB_RETIRE_CNT_EN
    exp_cnt = 32'd10;
`else
    exp_cnt = 32'd0;
`endif
    exp_wrap = 32'd0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 32'h0, 32'(i), 32'h0, 5'd1, 1'b1, 2'b00);
      step();
    end
    In_Stall = 1'b1;
    step(); step();
    In_Stall = 1'b0;
    In_Flush = 1'b1;
    step();
    In_Flush = 1'b0;
    In_Valid = 1'b0;
    step();
    checks++;
    if (Out_Retired !== exp_cnt) begin
      errors++; $display("FAIL retire_count: got %0d want %0d", Out_Retired, exp_cnt);
    end
`ifdef MEM_WB_RETIRE_CNT_EN
    force dut.retire_cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.retire_cnt_q;
`endif
    In_Valid = 1'b1;
    step();
    checks++;
    if (Out_Retired !== exp_wrap) begin
      errors++; $display("FAIL retire_wrap: got %h want %h", Out_Retired, exp_wrap);
    end
  endtask

  initial begin
    rst = 1'b1; In_Stall = 1'b0; In_Flush = 1'b0; In_Rs = '0; In_Rt = '0;
    set_in(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00);
    @(negedge clk);
    test_reset();
    test_stall_flush();
    test_r0_suppress();
    test_fwd_link();
    test_retire();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
